keccak_perm_arbiter: RTL

- Shares one KeccakF1600_StatePermute core between NUM_REQ requesters, e.g. the SHAKE128 matrix-expansion absorber/squeezer and the SHAKE256 secret-sampling absorber/squeezer in key generation.
- Each requester runs the codebase rtr/rts four-phase handshake with this block instead of with its own permutation core.
- The block grants requesters round-robin, forwards the granted 1600-bit state to the core, captures the permuted state and returns it to the granted requester.
- The core is instantiated outside this block; its A/Aout/rtr/rts pins connect to the perm_* ports.

---
 rtl/keccak_perm_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/keccak_perm_arbiter.sv
// Round-robin arbiter sharing one Keccak-f[1600] permutation core
// between NUM_REQ requesters over the rtr/rts four-phase handshake.
module keccak_perm_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        rtr,
    input  logic [NUM_REQ*1600-1:0]   linear_s_in,
    output logic [NUM_REQ-1:0]        rts,
    output logic [1599:0]             linear_s_out,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [1599:0]             perm_a,
    output logic                      perm_rtr,
    input  logic [1599:0]             perm_aout,
    input  logic                      perm_rts
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RELEASE,
        DONE
    } state_t;

    localparam logic [IDX_W:0]     N_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] last;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] pick;
    logic             pick_ok;
    logic [IDX_W:0]   cand;
    logic [1599:0]    slice [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign slice[k] = linear_s_in[1600*k +: 1600];
    end

    // Scan from farthest to nearest so the requester right after last wins.
    always_comb begin
        pick_ok = 1'b0;
        pick    = last;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last} + (IDX_W+1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            if (rtr[cand[IDX_W-1:0]]) begin
                pick_ok = 1'b1;
                pick    = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (pick_ok)     state_nxt = RUN;
            RUN:     if (perm_rts)    state_nxt = RELEASE;
            RELEASE: if (!perm_rts)   state_nxt = DONE;
            DONE:    if (!rtr[owner]) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rts          <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            perm_rtr     <= 1'b0;
            perm_a       <= '0;
            linear_s_out <= '0;
            owner        <= '0;
            last         <= IDX_W'(NUM_REQ-1);
        end else begin
            busy     <= (state_nxt != IDLE);
            perm_rtr <= (state_nxt == RUN);
            if (state == IDLE && pick_ok) begin
                grant  <= ONE << pick;
                owner  <= pick;
                perm_a <= slice[pick];
            end
            if (state == RUN && perm_rts) begin
                linear_s_out <= perm_aout;
            end
            if (state == RELEASE && !perm_rts) begin
                rts <= ONE << owner;
            end
            if (state == DONE && !rtr[owner]) begin
                rts   <= '0;
                grant <= '0;
                last  <= owner;
            end
        end
    end

endmodule
